pacing_scheduler: RTL and testbench
===================================

PACING_SCHEDULER -- requirements
Module: pacing_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: queue entries, power of two, at least 2.
REQ-002 Parameter PERIOD_0, default 10000: pacing period of periodic stream 0, in clk ticks (100 us at 100 MHz), at least 2.
REQ-003 Parameter PERIOD_1, default 20000: pacing period of periodic stream 1, in clk ticks, at least 2.
REQ-004 clk  in  1  single 100 MHz clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  global enable; 0 freezes capture, period counters and timestamp.
REQ-007 x1, x2, x3  in  32 each  signed input stream values.
REQ-008 hasX1, hasX2, hasX3  in  1 each  per-input "new value this cycle" strobes.
REQ-009 ev_valid  out  1  head queue entry available to the monitor.
REQ-010 ev_ready  in  1  monitor accepts head entry.
REQ-011 ev_x1, ev_x2, ev_x3  out  32 each  head-entry values.
REQ-012 ev_has  out  3  head-entry strobes {hasX3,hasX2,hasX1}.
REQ-013 ev_pace  out  2  head-entry periodic enables {stream1,stream0}.
REQ-014 ev_time  out  32  head-entry capture timestamp.
REQ-015 ovf  out  1  sticky: an input event was dropped.
REQ-016 pace_miss  out  1  sticky: a pacing tick was lost.

Function
REQ-017 Free-running 32-bit tick counter increments each cycle with en=1 and wraps from 0xFFFFFFFF to 0.
REQ-018 Each period counter counts 0..PERIOD_n-1 while en=1; the cycle at count PERIOD_n-1 is a tick for stream n, and the counter then returns to 0.
REQ-019 A tick sets the stream's pend_pace bit; pend bits are ORed into the next enqueued entry and cleared in that same cycle.
REQ-020 Enqueue occurs in a cycle with en=1 and (any hasX or any pend/tick bit) and space; space = count<DEPTH or (ev_valid and ev_ready).
REQ-021 Entry contents are x1..x3 and hasX as sampled; x values with hasX=0 are stored as 0; pace = pend OR current ticks; time = tick counter value.
REQ-022 Input event and tick in the same cycle produce one merged entry, never two.
REQ-023 An input event arriving without space is dropped and sets ovf; pace bits stay pending.
REQ-024 A tick for stream n while pend_pace[n] is already set and not enqueued that cycle sets pace_miss.
REQ-025 Queue is FIFO; ev_* show the head combinationally from queue registers; ev_valid = (count>0).
REQ-026 Latency: an event sampled at edge k is visible on ev_valid after edge k when the queue was empty.
REQ-027 Head pops on an edge with ev_valid and ev_ready; ev_* stay stable while ev_valid=1 and ev_ready=0.
REQ-028 en=0 does not block draining; handshake continues and no enqueue occurs.
REQ-029 ev_ready with ev_valid=0 is ignored.

Reset
REQ-030 rst=0 immediately clears queue count and pointers, period counters, tick counter, pend bits, ovf and pace_miss.
REQ-031 During reset, ev_valid=0, ev_has=0, ev_pace=0, ev_x*=0 and ev_time=0.
REQ-032 Reset mid-operation discards all queued entries; the first tick after release comes PERIOD_n enabled cycles later.

Configuration
REQ-033 With PACING_TIMESTAMP_EN defined, the tick counter exists and ev_time carries the entry timestamp.
REQ-034 Without PACING_TIMESTAMP_EN, the tick counter and timestamp storage are removed and ev_time is tied to 0; all other behaviour is unchanged.

Verification (bench: PERIOD_0=4, PERIOD_1=8, DEPTH=4, timestamp enabled)
REQ-035 Pace only: en=1, no inputs, ev_ready=1 -> ev_pace=01 entries every 4 cycles, and ev_pace=11 every 8th cycle as one entry.
REQ-036 Merge: hasX1=hasX2=1, x1=1, x2=2 on a stream-0 tick cycle -> single entry ev_has=011, ev_x1=1, ev_x2=2, ev_x3=0, ev_pace=01.
REQ-037 Backpressure: ev_ready=0, inject 5 single-cycle x1 events (values 4..8) -> first 4 queued, 5th dropped, ovf=1; releasing ev_ready pops 4,5,6,7 in order.
REQ-038 Pace miss: ev_ready=0 with the queue full for more than 4 cycles -> pace_miss=1; the pending bit is delivered once space frees.
REQ-039 Reset mid-run: assert rst with 3 entries queued -> ev_valid=0 at once; after release the first stream-0 tick appears 4 enabled cycles later with ev_time=3.
REQ-040 en gating: en=0 for 10 cycles -> no new entries, ev_time of the next entry continues from the frozen count, queued entries still drain.

Source files
------------

// File: rtl/pacing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pacing_scheduler
//  Brief    : Merges three sampled input streams and two periodic pacing
//             ticks into a FIFO of timestamped monitor events with
//             valid/ready hand-off, sticky overflow and pace-miss flags.
//  Options  : PACING_TIMESTAMP_EN - keep the 32-bit tick counter and per-entry
//             timestamp; when undefined ev_time is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pacing_scheduler #(
  parameter int DEPTH    = 4,
  parameter int PERIOD_0 = 10000,
  parameter int PERIOD_1 = 20000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [31:0] x1,
  input  logic signed [31:0] x2,
  input  logic signed [31:0] x3,
  input  logic               hasX1,
  input  logic               hasX2,
  input  logic               hasX3,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic signed [31:0] ev_x1,
  output logic signed [31:0] ev_x2,
  output logic signed [31:0] ev_x3,
  output logic [2:0]         ev_has,
  output logic [1:0]         ev_pace,
  output logic [31:0]        ev_time,
  output logic               ovf,
  output logic               pace_miss
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int PW0 = $clog2(PERIOD_0);
  localparam int PW1 = $clog2(PERIOD_1);

  localparam logic [PW0-1:0] c_last0 = PW0'(PERIOD_0 - 1);
  localparam logic [PW1-1:0] c_last1 = PW1'(PERIOD_1 - 1);
  localparam logic [CW-1:0]  c_depth = CW'(DEPTH);

  logic [PW0-1:0] r_pcnt0;
  logic [PW1-1:0] r_pcnt1;
  logic [1:0]     r_pend;
  logic [CW-1:0]  r_count;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic           r_ovf;
  logic           r_pace_miss;

  logic [31:0] r_mem_x1   [DEPTH];
  logic [31:0] r_mem_x2   [DEPTH];
  logic [31:0] r_mem_x3   [DEPTH];
  logic [2:0]  r_mem_has  [DEPTH];
  logic [1:0]  r_mem_pace [DEPTH];

  logic [1:0] w_tick;
  logic [2:0] w_has;
  logic       w_pop;
  logic       w_space;
  logic       w_push;

  assign w_tick[0] = en && (r_pcnt0 == c_last0);
  assign w_tick[1] = en && (r_pcnt1 == c_last1);
  assign w_has     = {hasX3, hasX2, hasX1};
  assign ev_valid  = (r_count != '0);
  assign w_pop     = ev_valid && ev_ready;
  assign w_space   = (r_count < c_depth) || w_pop;
  // Inputs and ticks of one cycle always land in a single merged entry.
  assign w_push    = en && ((|w_has) || (|r_pend) || (|w_tick)) && w_space;

  // Period counters: run 0..PERIOD_n-1 while enabled, the last count is the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt0 <= '0;
      r_pcnt1 <= '0;
    end else if (en) begin
      r_pcnt0 <= w_tick[0] ? '0 : r_pcnt0 + PW0'(1);
      r_pcnt1 <= w_tick[1] ? '0 : r_pcnt1 + PW1'(1);
    end
  end

  // Pending pace bits: hold ticks until an entry carries them; flag a tick lost on top of a pending one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend      <= '0;
      r_pace_miss <= 1'b0;
    end else begin
      if (w_push) begin
        r_pend <= '0;
      end else begin
        r_pend <= r_pend | w_tick;
        if (|(w_tick & r_pend)) begin
          r_pace_miss <= 1'b1;
        end
      end
    end
  end

  // Overflow: an input event with no room is dropped and remembered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (en && (|w_has) && !w_space) begin
      r_ovf <= 1'b1;
    end
  end

  // Queue bookkeeping: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: values without a strobe are stored as zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x1[r_wr_ptr]   <= hasX1 ? x1 : '0;
      r_mem_x2[r_wr_ptr]   <= hasX2 ? x2 : '0;
      r_mem_x3[r_wr_ptr]   <= hasX3 ? x3 : '0;
      r_mem_has[r_wr_ptr]  <= w_has;
      r_mem_pace[r_wr_ptr] <= r_pend | w_tick;
    end
  end

  // Head view is gated by ev_valid so an empty or resetting queue shows zeros.
  assign ev_x1     = ev_valid ? r_mem_x1[r_rd_ptr]   : '0;
  assign ev_x2     = ev_valid ? r_mem_x2[r_rd_ptr]   : '0;
  assign ev_x3     = ev_valid ? r_mem_x3[r_rd_ptr]   : '0;
  assign ev_has    = ev_valid ? r_mem_has[r_rd_ptr]  : '0;
  assign ev_pace   = ev_valid ? r_mem_pace[r_rd_ptr] : '0;
  assign ovf       = r_ovf;
  assign pace_miss = r_pace_miss;

`ifdef PACING_TIMESTAMP_EN
  logic [31:0] r_tstamp;
  logic [31:0] r_mem_time [DEPTH];

  // Free-running timestamp, frozen while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tstamp <= '0;
    end else if (en) begin
      r_tstamp <= r_tstamp + 32'd1;
    end
  end

  // Timestamp storage alongside each queued entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_time[r_wr_ptr] <= r_tstamp;
    end
  end

  assign ev_time = ev_valid ? r_mem_time[r_rd_ptr] : '0;
`else
  assign ev_time = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pacing_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pacing_scheduler
//  Brief    : Directed bench for pacing_scheduler (PERIOD_0=4, PERIOD_1=8,
//             DEPTH=4) with hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pacing_scheduler;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic signed [31:0] x1 = '0, x2 = '0, x3 = '0;
  logic               hasX1 = 1'b0, hasX2 = 1'b0, hasX3 = 1'b0;
  logic               ev_ready = 1'b0;
  logic               ev_valid;
  logic signed [31:0] ev_x1, ev_x2, ev_x3;
  logic [2:0]         ev_has;
  logic [1:0]         ev_pace;
  logic [31:0]        ev_time;
  logic               ovf, pace_miss;

  int n_vec = 0;
  int n_err = 0;

  pacing_scheduler #(.DEPTH(4), .PERIOD_0(4), .PERIOD_1(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .x1(x1), .x2(x2), .x3(x3),
    .hasX1(hasX1), .hasX2(hasX2), .hasX3(hasX3),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x1(ev_x1), .ev_x2(ev_x2), .ev_x3(ev_x3),
    .ev_has(ev_has), .ev_pace(ev_pace), .ev_time(ev_time),
    .ovf(ovf), .pace_miss(pace_miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Timestamp expectations collapse to zero when the timestamp option is off.
  task automatic chk_time(input string tag, input logic [31:0] exp);
`ifdef PACING_TIMESTAMP_EN
    check(tag, ev_time, exp);
`else
    check(tag, ev_time, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hasX1 = 1'b0; hasX2 = 1'b0; hasX3 = 1'b0;
    x1 = '0; x2 = '0; x3 = '0;
  endtask

  // Asynchronous assert, check immediate clearing, hold over two edges, release.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst valid", ev_valid, 0);
    check("rst ovf", ovf, 0);
    check("rst pace_miss", pace_miss, 0);
    en = 1'b0; ev_ready = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    check("reset valid", ev_valid, 0);
    check("reset has", ev_has, 0);
    check("reset pace", ev_pace, 0);
    check("reset x1", ev_x1, 0);
    check("reset time", ev_time, 0);
    step();
    step();
    rst = 1'b1;

    // ---------------- pace only ----------------
    en = 1'b1; ev_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("pace valid k=%0d", k), ev_valid, (k % 4 == 0) ? 1 : 0);
      if (k % 4 == 0) begin
        check($sformatf("pace bits k=%0d", k), ev_pace, (k % 8 == 0) ? 32'd3 : 32'd1);
        check($sformatf("pace has k=%0d", k), ev_has, 0);
        chk_time($sformatf("pace time k=%0d", k), k - 1);
      end
    end

    // ---------------- merge ----------------
    do_reset();
    en = 1'b1; ev_ready = 1'b0;
    step(); step(); step();
    check("merge pre valid", ev_valid, 0);
    hasX1 = 1'b1; hasX2 = 1'b1; x1 = 1; x2 = 2; x3 = 55;
    step();
    clear_inputs();
    check("merge valid", ev_valid, 1);
    check("merge has", ev_has, 3'b011);
    check("merge x1", ev_x1, 1);
    check("merge x2", ev_x2, 2);
    check("merge x3", ev_x3, 0);
    check("merge pace", ev_pace, 2'b01);
    chk_time("merge time", 3);
    ev_ready = 1'b1;
    step();
    check("merge single", ev_valid, 0);

    // ---------------- backpressure ----------------
    do_reset();
    en = 1'b1; ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("bp ovf before", ovf, 0);
      hasX1 = 1'b1; x1 = 4 + i;
      step();
    end
    clear_inputs();
    check("bp ovf", ovf, 1);
    check("bp valid", ev_valid, 1);
    ev_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp order %0d", j), ev_x1, 4 + j);
      check($sformatf("bp has %0d", j), ev_has, 3'b001);
      if (j == 3) begin
        check("bp merged pace", ev_pace, 2'b01);
        chk_time("bp merged time", 3);
      end
      step();
    end
    check("bp tick pace", ev_pace, 2'b11);
    check("bp tick x1", ev_x1, 0);
    chk_time("bp tick time", 7);
    step();
    check("bp drained", ev_valid, 0);
    check("bp ovf sticky", ovf, 1);

    // ---------------- pace miss ----------------
    do_reset();
    en = 1'b1; ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hasX1 = 1'b1; x1 = i + 1;
      step();
    end
    clear_inputs();
    for (int i = 0; i < 4; i++) step();
    check("pm first pend", pace_miss, 0);
    check("pm head stable", ev_x1, 1);
    for (int i = 0; i < 4; i++) step();
    check("pm set", pace_miss, 1);
    ev_ready = 1'b1;
    step();
    check("pm pop2", ev_x1, 2);
    step();
    check("pm pop3", ev_x1, 3);
    step();
    check("pm pop4", ev_x1, 4);
    step();
    check("pm pend pace", ev_pace, 2'b11);
    check("pm pend has", ev_has, 0);
    chk_time("pm pend time", 12);
    step();
    check("pm next pace", ev_pace, 2'b11);
    chk_time("pm next time", 15);
    check("pm sticky", pace_miss, 1);

    // ---------------- reset mid-run ----------------
    do_reset();
    en = 1'b1; ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hasX1 = 1'b1; x1 = i + 1;
      step();
    end
    clear_inputs();
    check("mid queued", ev_valid, 1);
    rst = 1'b0;
    #1;
    check("mid valid", ev_valid, 0);
    check("mid has", ev_has, 0);
    check("mid x1", ev_x1, 0);
    step();
    rst = 1'b1; ev_ready = 1'b1;
    step(); step(); step();
    check("mid no early tick", ev_valid, 0);
    step();
    check("mid tick valid", ev_valid, 1);
    check("mid tick pace", ev_pace, 2'b01);
    chk_time("mid tick time", 3);

    // ---------------- enable gating ----------------
    do_reset();
    en = 1'b1; ev_ready = 1'b0;
    hasX1 = 1'b1; x1 = 9;
    step();
    x1 = 10;
    step();
    en = 1'b0; ev_ready = 1'b1; x1 = 77;
    step();
    check("en drain head", ev_x1, 10);
    chk_time("en drain time", 1);
    step();
    check("en drained", ev_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("en frozen %0d", i), ev_valid, 0);
    end
    check("en no ovf", ovf, 0);
    en = 1'b1; x1 = 42;
    step();
    clear_inputs();
    check("en resume x1", ev_x1, 42);
    check("en resume pace", ev_pace, 0);
    chk_time("en resume time", 2);
    step();
    check("en tick pace", ev_pace, 2'b01);
    check("en tick has", ev_has, 0);
    chk_time("en tick time", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
